// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared sizing helpers for the host bus arbiter
package bus_pkg;

  // Width of a host index; a single host still needs one bit to name it.
  function automatic int host_idx_w(input int nr_hosts);
    return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
  endfunction

endpackage

// File: rtl/bus_rsp_id_fifo.sv
// rtl/bus_rsp_id_fifo.sv - flop-based FIFO holding host IDs of outstanding requests
module bus_rsp_id_fifo #(
  parameter int Width = 1,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (count_q == CntW'(Depth));
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter sharing one device bus port between hosts
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NrHosts-1:0]                host_req_i,
  output logic [NrHosts-1:0]                host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                host_we_i,
  input  logic [NrHosts*(DataWidth/8)-1:0]  host_be_i,
  input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                host_rvalid_o,
  output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                host_err_o,
  output logic                              dev_req_o,
  input  logic                              dev_gnt_i,
  output logic [AddressWidth-1:0]           dev_addr_o,
  output logic                              dev_we_o,
  output logic [DataWidth/8-1:0]            dev_be_o,
  output logic [DataWidth-1:0]              dev_wdata_o,
  input  logic                              dev_rvalid_i,
  input  logic [DataWidth-1:0]              dev_rdata_i,
  input  logic                              dev_err_i,
  output logic                              unexp_rsp_o
);

  localparam int IdxW = host_idx_w(NrHosts);
  localparam int BeW  = DataWidth / 8;

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] cand_idx;
  logic [IdxW-1:0] head_id;
  logic            any_req;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            accept;

  // Rotating-priority find-first starting at the pointer.
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    cand_idx = '0;
    for (int i = 0; i < NrHosts; i++) begin
      cand_idx = IdxW'((int'(ptr_q) + i) % NrHosts);
      if (!any_req && host_req_i[cand_idx]) begin
        any_req = 1'b1;
        winner  = cand_idx;
      end
    end
  end

  // A response arriving with no ID outstanding is never matched to a same-cycle push.
  assign pop       = dev_rvalid_i & ~fifo_empty;
  assign dev_req_o = any_req & (~fifo_full | pop);
  assign accept    = dev_req_o & dev_gnt_i;

  assign dev_addr_o  = host_addr_i[int'(winner)*AddressWidth +: AddressWidth];
  assign dev_we_o    = host_we_i[winner];
  assign dev_be_o    = host_be_i[int'(winner)*BeW +: BeW];
  assign dev_wdata_o = host_wdata_i[int'(winner)*DataWidth +: DataWidth];

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    if (accept) begin
      host_gnt_o[winner] = 1'b1;
    end
    if (pop) begin
      host_rvalid_o[head_id]                              = 1'b1;
      host_rdata_o[int'(head_id)*DataWidth +: DataWidth]  = dev_rdata_i;
      host_err_o[head_id]                                 = dev_err_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      unexp_rsp_o <= 1'b0;
    end else begin
      if (accept) begin
        ptr_q <= IdxW'((int'(winner) + 1) % NrHosts);
      end
      if (dev_rvalid_i && fifo_empty) begin
        unexp_rsp_o <= 1'b1;
      end
    end
  end

  bus_rsp_id_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_rsp_id_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (accept),
    .push_data_i (winner),
    .pop_i       (pop),
    .pop_data_o  (head_id),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule
